mant_multiplier: RTL and testbench
==================================

# mant_multiplier

Iterative radix-2 shift-and-add mantissa multiplier for the FP datapath. It is the multiply-side counterpart of the mantissa divider and uses the same `en`/`done` operand convention. It accepts two hidden-bit-inclusive unsigned mantissas and produces a normalized product with guard/round bits, a sticky bit and a normalization-overflow flag. The FP multiply unit consumes these outputs for exponent adjust and rounding.

## Interface
- `MANT_WIDTH`, default 10: stored mantissa width. Operands are MANT_WIDTH+1 bits including the hidden bit. MANT_WIDTH ≥ 3 is required.
- `CLK` input, 1 bit: clock, rising-edge.
- `nRST` input, 1 bit: reset, synchronous, active-low.
- `en` input, 1 bit: start request. Sampled only in IDLE.
- `x` input, [MANT_WIDTH:0]: multiplicand, unsigned, captured on accept.
- `y` input, [MANT_WIDTH:0]: multiplier, unsigned, captured on accept.
- `result` output, [MANT_WIDTH+2:0]: normalized product top bits. The result is the mantissa (MANT_WIDTH+1 bits), followed by guard, followed by round.
- `sticky` output, 1 bit: OR of all product bits below `result`.
- `ovf` output, 1 bit: 1 when the full product bit 2·MANT_WIDTH+1 is set (product ≥ 2.0). The exponent is then incremented downstream.
- `done` output, 1 bit: one-cycle pulse. `result`, `sticky` and `ovf` are valid in the same cycle.
- `busy` output, 1 bit: high whenever state ≠ IDLE.

## Operation
- **States.** IDLE, MUL, NORM.
- **IDLE.**
  - If `en`=1 at an edge: m←x, Q←y, A←0, n←MANT_WIDTH, then go to MUL.
  - Otherwise stay in IDLE.
- **MUL, one iteration per edge.**
  - Compute S = (Q[0] ? A+m : A), where S is MANT_WIDTH+2 bits wide and its carry is kept.
  - Update {A,Q} ← {S,Q} >> 1 (logical shift).
  - Update n←n−1.
  - On the edge where n==0, go to NORM.
- **Product.** After the MANT_WIDTH+1 iterations, P = {A[MANT_WIDTH:0],Q} is 2·MANT_WIDTH+2 bits and equals x·y exactly.
- **NORM, single edge.** Register the outputs, set `done`←1, return to IDLE.
  - If P[2W+1]=1: `result`←P[2W+1:W−1], `sticky`←|P[W−2:0], `ovf`←1.
  - Else: `result`←P[2W:W−2], `sticky`←|P[W−3:0], `ovf`←0.
  - W here denotes MANT_WIDTH.
- **Zero operand.** P=0 gives `result`=0, `sticky`=0, `ovf`=0. There is no special-casing; the normal path handles it, with the same latency.
- **No normalization for denormals.** If neither input has its hidden bit set, `result` is P[2W:W−2] as-is (possibly leading zeros). Denormal handling is done downstream.
- **`en` while busy.** `en` is ignored; the operands are not re-captured.
- **Output hold.** `result`, `sticky` and `ovf` hold their value until the next NORM edge. `done` is high for exactly one cycle.
- **Reset mid-operation.** `nRST`=0 at any edge returns to IDLE and clears A, Q, m, n and all outputs. The in-flight operation is discarded and `done` is not emitted.

## Timing
- **Reset values.** `result`=0, `sticky`=0, `ovf`=0, `done`=0, `busy`=0, state=IDLE.
- **Latency.** The accept edge is E0. MUL occupies edges E1..E(MANT_WIDTH+1). NORM is at edge E(MANT_WIDTH+2). `done` is high in the cycle following E(MANT_WIDTH+2).
  - For MANT_WIDTH=10: accept at E0, `done` after E12.
- **`busy` window.** `busy` is high from after E0 through after E(MANT_WIDTH+1). It is low in the `done` cycle.
- **Back-to-back.** `en`=1 in the `done` cycle is accepted, since state is IDLE. The throughput is one operation per MANT_WIDTH+3 cycles.
- **Combinational paths.** There is no combinational path from the inputs to the outputs. All outputs are registered.

## Test plan
1. **Reset:** hold `nRST`=0 for 2 cycles → all outputs 0, `busy`=0. Then pulse `en` with x=y=0x400 → `done` asserted exactly 12 cycles after the accept edge.
2. **1.0×1.0:** x=0x400, y=0x400 → `result`=0x1000, `sticky`=0, `ovf`=0.
3. **1.5×1.5:** x=0x600, y=0x600 → P=0x240000, `result`=0x1200, `sticky`=0, `ovf`=1.
4. **Max×max:** x=0x7FF, y=0x7FF → P=0x3FF001, `result`=0x1FF8, `sticky`=1, `ovf`=1.
5. **`en` while busy, then back-to-back:**
   - Start x=0x400, y=0x401.
   - Toggle `en` with x=0x7FF mid-operation → result is still 0x1004 with `sticky`=0 and `ovf`=0.
   - Assert `en` in the `done` cycle with x=0x600, y=0x600 → the second `done` arrives 12 cycles later with `result`=0x1200.
6. **Reset mid-operation and zero operand:**
   - Start with x=0x7FF, y=0x7FF; drop `nRST` at E5 → no `done`, outputs 0.
   - Then x=0, y=0x7FF → `result`=0, `sticky`=0, `ovf`=0 after 12 cycles.

Source files
------------

// File: rtl/mant_multiplier.sv
// mant_multiplier
//
// Iterative radix-2 shift-and-add multiplier for hidden-bit-inclusive
// mantissas. One partial-product step is taken per clock. The raw
// 2*MANT_WIDTH+2 bit product is then normalized into mantissa + guard +
// round, a sticky bit, and an overflow flag (product >= 2.0) that the
// FP multiply unit uses to adjust the exponent.
//
// Ports
//   CLK     in   rising-edge clock
//   nRST    in   synchronous active-low reset
//   en      in   start request, only looked at while idle
//   x, y    in   [MANT_WIDTH:0] unsigned operands, captured on accept
//   result  out  [MANT_WIDTH+2:0] normalized product {mantissa, guard, round}
//   sticky  out  OR of all product bits below result
//   ovf     out  product bit 2*MANT_WIDTH+1 was set
//   done    out  one-cycle pulse; result/sticky/ovf valid with it
//   busy    out  operation in flight
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for en; operands captured on the accepting edge
// MUL    | one shift-and-add step per edge, MANT_WIDTH+1 steps total
// NORM   | normalize the product, register outputs, pulse done
//
// MANT_WIDTH must be at least 3 so every normalization slice is legal.

module mant_multiplier #(
  parameter int MANT_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  en,
  input  logic [MANT_WIDTH:0]   x,
  input  logic [MANT_WIDTH:0]   y,
  output logic [MANT_WIDTH+2:0] result,
  output logic                  sticky,
  output logic                  ovf,
  output logic                  done,
  output logic                  busy
);

  localparam int W     = MANT_WIDTH;
  localparam int PW    = 2 * W + 2;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W:0]       a_q, a_d;
  logic [W:0]       q_q, q_d;
  logic [W:0]       m_q, m_d;
  logic [CNT_W-1:0] n_q, n_d;

  logic [W+2:0] result_q, result_d;
  logic         sticky_q, sticky_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;

  // control strobes from the output decoder
  logic load;
  logic step;
  logic finish;
  logic last_step;

  assign last_step = (n_q == CNT_ZERO);

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en)        state_d = ST_MUL;
      ST_MUL:  if (last_step) state_d = ST_NORM;
      ST_NORM:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    busy   = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        load = en;
      end
      ST_MUL:  step   = 1'b1;
      ST_NORM: finish = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------
  // Shift-and-add datapath
  // ---------------------------------------------------------------
  // The sum keeps its carry so A+m never loses the top bit; the carry
  // becomes A's MSB after the right shift.
  logic [W+1:0] sum;
  assign sum = q_q[0] ? ({1'b0, a_q} + {1'b0, m_q}) : {1'b0, a_q};

  always_comb begin
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    n_d = n_q;
    if (load) begin
      a_d = '0;
      q_d = y;
      m_d = x;
      n_d = CNT_INIT;
    end else if (step) begin
      a_d = sum[W+1:1];
      q_d = {sum[0], q_q[W:1]};
      n_d = n_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      n_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
      n_q <= n_d;
    end
  end

  // ---------------------------------------------------------------
  // Normalization
  // ---------------------------------------------------------------
  // No leading-zero shift: a product without a hidden bit (denormal
  // input) falls into the low slice as-is and is fixed up downstream.
  logic [PW-1:0] prod;
  logic          prod_msb;
  logic [W+2:0]  res_hi, res_lo;
  logic          sticky_hi, sticky_lo;

  assign prod      = {a_q, q_q};
  assign prod_msb  = prod[PW-1];
  assign res_hi    = prod[PW-1:W-1];
  assign res_lo    = prod[PW-2:W-2];
  assign sticky_hi = |prod[W-2:0];
  assign sticky_lo = |prod[W-3:0];

  always_comb begin
    result_d = result_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (finish) begin
      done_d   = 1'b1;
      ovf_d    = prod_msb;
      result_d = prod_msb ? res_hi : res_lo;
      sticky_d = prod_msb ? sticky_hi : sticky_lo;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      result_q <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign sticky = sticky_q;
  assign ovf    = ovf_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mant_multiplier.sv
module tb_mant_multiplier;

  localparam int W   = 10;
  localparam int LAT = W + 3;  // negedges from the driving negedge to the done cycle

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic           en = 1'b0;
  logic [W:0]     x = '0;
  logic [W:0]     y = '0;
  logic [W+2:0]   result;
  logic           sticky;
  logic           ovf;
  logic           done;
  logic           busy;

  mant_multiplier #(.MANT_WIDTH(W)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .en     (en),
    .x      (x),
    .y      (y),
    .result (result),
    .sticky (sticky),
    .ovf    (ovf),
    .done   (done),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [W+2:0] res;
    logic         st;
    logic         ov;
    int           at_cyc;
  } exp_t;

  exp_t sb[$];

  // Reference: exact integer product, then pick the slice by its top bit.
  function automatic exp_t model(input logic [W:0] a, input logic [W:0] b);
    exp_t         e;
    logic [63:0]  p;
    logic [63:0]  mask_hi, mask_lo;
    p       = 64'(a) * 64'(b);
    mask_hi = (64'd1 << (W - 1)) - 1;
    mask_lo = (64'd1 << (W - 2)) - 1;
    e.ov    = p[2*W+1];
    if (e.ov) begin
      e.res = (W+3)'(p >> (W - 1));
      e.st  = (p & mask_hi) != 0;
    end else begin
      e.res = (W+3)'(p >> (W - 2));
      e.st  = (p & mask_lo) != 0;
    end
    e.at_cyc = 0;
    return e;
  endfunction

  // Called at a negedge: the next posedge accepts the operands.
  task automatic drive_op(input logic [W:0] a, input logic [W:0] b);
    exp_t e;
    en = 1'b1;
    x  = a;
    y  = b;
    e  = model(a, b);
    e.at_cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      @(negedge CLK);
    end
    check_eq("done_timeout", 0, 1);
  endtask

  always @(negedge CLK) begin
    if (nRST && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("result",  result, e.res);
        check_eq("sticky",  sticky, e.st);
        check_eq("ovf",     ovf,    e.ov);
        check_eq("latency", cyc,    e.at_cyc);
        check_eq("busy_in_done", busy, 0);
      end
    end
  end

  task automatic run_op(input logic [W:0] a, input logic [W:0] b);
    @(negedge CLK);
    drive_op(a, b);
    @(negedge CLK);
    en = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_result", result, 0);
    check_eq("rst_sticky", sticky, 0);
    check_eq("rst_ovf",    ovf,    0);
    check_eq("rst_done",   done,   0);
    check_eq("rst_busy",   busy,   0);
    nRST = 1'b1;

    // first op: 1.0 x 1.0, also checks busy right after accept
    @(negedge CLK);
    drive_op(11'h400, 11'h400);
    @(negedge CLK);
    en = 1'b0;
    check_eq("busy_after_accept", busy, 1);
    wait_done();

    run_op(11'h600, 11'h600);
    run_op(11'h7FF, 11'h7FF);

    // en while busy is ignored, then a back-to-back start in the done cycle
    @(negedge CLK);
    drive_op(11'h400, 11'h401);
    @(negedge CLK);
    en = 1'b0;
    repeat (3) @(negedge CLK);
    en = 1'b1;
    x  = 11'h7FF;
    y  = 11'h7FF;
    @(negedge CLK);
    en = 1'b0;
    wait_done();
    drive_op(11'h600, 11'h600);
    @(negedge CLK);
    en = 1'b0;
    check_eq("busy_b2b", busy, 1);
    wait_done();

    // reset mid-operation: nRST low sampled at E5
    @(negedge CLK);
    drive_op(11'h7FF, 11'h7FF);
    @(negedge CLK);
    en = 1'b0;
    repeat (4) @(negedge CLK);
    nRST = 1'b0;
    sb.delete();
    @(negedge CLK);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_ovf",    ovf,    0);
    check_eq("midrst_busy",   busy,   0);
    nRST = 1'b1;
    repeat (15) @(negedge CLK);
    check_eq("midrst_no_done", done, 0);

    // zero operand and a denormal-style product
    run_op(11'h000, 11'h7FF);
    run_op(11'h0FF, 11'h1F3);

    for (int k = 0; k < 8; k++) begin
      run_op(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
    end

    repeat (3) @(negedge CLK);
    check_eq("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
